// File: rtl/conv3x3_relu_pool_engine.sv
// conv3x3_relu_pool_engine: zero-padded 3x3 conv + bias, rounding, ReLU/saturate.
// Build option CONV_POOL_EN adds the 2x2 max-pool layer write.
module conv3x3_relu_pool_engine #(
  parameter int IMG_LOG2 = 6,
  parameter int DW       = 20,
  parameter int KW       = 20,
  parameter int FRAC     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ready,
  output logic                  busy,
  input  logic                  k_we,
  input  logic [3:0]            k_idx,
  input  logic [KW-1:0]         k_data,
  output logic [2*IMG_LOG2-1:0] iaddr,
  input  logic [DW-1:0]         idata,
  output logic                  cwr,
  output logic [2:0]            csel,
  output logic [2*IMG_LOG2-1:0] caddr_wr,
  output logic [DW-1:0]         cdata_wr,
  output logic                  done
);

  localparam int L  = IMG_LOG2;
  localparam int AW = DW + KW + 5;
  localparam int PW = DW + KW + 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_TAP  = 3'd1;
  localparam logic [2:0] S_ACC  = 3'd2;
  localparam logic [2:0] S_WR0  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
`ifdef CONV_POOL_EN
  localparam logic [2:0] S_WR1  = 3'd5;
`endif

  logic [2:0]           r_state;
  logic [3:0]           r_tap;
  logic [3:0]           r_ptap;
  logic                 r_tvld;
  logic [2*L-1:0]       r_pix;
  logic signed [AW-1:0] r_acc;
  logic signed [KW-1:0] r_w [0:9];
  logic                 r_busy;
  logic                 r_done;
  logic                 r_cwr;
  logic [2:0]           r_csel;
  logic [2*L-1:0]       r_iaddr;
  logic [2*L-1:0]       r_caddr;
  logic [DW-1:0]        r_cdata;

  logic [L-1:0]         w_row;
  logic [L-1:0]         w_col;
  logic [1:0]           w_dr;
  logic [1:0]           w_dc;
  logic [L+1:0]         w_rr;
  logic [L+1:0]         w_cc;
  logic                 w_tvld;
  logic signed [KW-1:0] w_wt;
  logic signed [PW-1:0] w_px;
  logic signed [PW-1:0] w_wx;
  logic signed [PW-1:0] w_prod;
  logic signed [AW-1:0] w_add;
  logic signed [AW-1:0] w_sum;
  logic signed [AW-1:0] w_bias;
  logic signed [AW-1:0] w_half;
  logic signed [AW-1:0] w_rin;
  logic signed [AW-1:0] w_rnd;
  logic [DW-1:0]        w_res;

  // traversal index is {win_row, win_col, sub}; sub walks TL, TR, BL, BR
  assign w_row = {r_pix[2*L-1:L+1], r_pix[1]};
  assign w_col = {r_pix[L:2], r_pix[0]};

  // tap t covers row offset t/3-1 and column offset t%3-1
  always_comb begin
    w_dr = 2'd0;
    w_dc = 2'd0;
    if (r_tap >= 4'd6) begin
      w_dr = 2'd2;
      w_dc = 2'(r_tap - 4'd6);
    end else if (r_tap >= 4'd3) begin
      w_dr = 2'd1;
      w_dc = 2'(r_tap - 4'd3);
    end else begin
      w_dc = r_tap[1:0];
    end
  end

  // two guard bits catch both -1 and W as out of image
  assign w_rr   = {2'b00, w_row} + {{L{1'b0}}, w_dr}
                - {{(L+1){1'b0}}, 1'b1};
  assign w_cc   = {2'b00, w_col} + {{L{1'b0}}, w_dc}
                - {{(L+1){1'b0}}, 1'b1};
  assign w_tvld = (w_rr[L+1:L] == 2'b00) && (w_cc[L+1:L] == 2'b00);

  assign w_wt   = r_w[r_ptap];
  assign w_px   = $signed({{(KW+1){1'b0}}, idata});
  assign w_wx   = $signed({{(DW+1){w_wt[KW-1]}}, w_wt});
  assign w_prod = w_px * w_wx;
  assign w_add  = r_tvld ? {{(AW-PW){w_prod[PW-1]}}, w_prod} : '0;
  assign w_sum  = r_acc + w_add;
  assign w_bias = {{(AW-KW-FRAC){r_w[9][KW-1]}}, r_w[9], {FRAC{1'b0}}};
  assign w_half = {{(AW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  assign w_rin  = w_sum + w_half;
  assign w_rnd  = w_rin >>> FRAC;

  // ReLU on negative, clamp to all-ones on overflow
  always_comb begin
    w_res = w_rnd[DW-1:0];
    if (w_rnd[AW-1])
      w_res = '0;
    else if (|w_rnd[AW-2:DW])
      w_res = '1;
  end

`ifdef CONV_POOL_EN
  logic [DW-1:0] r_max;
  logic [DW-1:0] w_max;

  assign w_max = (r_pix[1:0] == 2'd0 || w_res > r_max) ? w_res : r_max;

  // running max restarts with the TL pixel of each window
  always_ff @(posedge clk) begin
    if (reset)
      r_max <= '0;
    else if (r_state == S_ACC)
      r_max <= w_max;
  end
`endif

  // kernel/bias registers, frozen while a frame is running
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 10; i++)
        r_w[i] <= '0;
    end else if (k_we && !r_busy && k_idx <= 4'd9) begin
      r_w[k_idx] <= k_data;
    end
  end

  // frame sequencer, tap pipeline and layer-write outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_tap   <= '0;
      r_ptap  <= '0;
      r_tvld  <= 1'b0;
      r_pix   <= '0;
      r_acc   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cwr   <= 1'b0;
      r_csel  <= 3'b000;
      r_iaddr <= '0;
      r_caddr <= '0;
      r_cdata <= '0;
    end else begin
      r_cwr  <= 1'b0;
      r_csel <= 3'b000;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ready) begin
            r_state <= S_TAP;
            r_busy  <= 1'b1;
            r_tap   <= '0;
            r_pix   <= '0;
          end
        end
        S_TAP: begin
          r_iaddr <= {w_rr[L-1:0], w_cc[L-1:0]};
          r_tvld  <= w_tvld;
          r_ptap  <= r_tap;
          r_acc   <= (r_tap == 4'd0) ? w_bias : w_sum;
          if (r_tap == 4'd8) begin
            r_tap   <= '0;
            r_state <= S_ACC;
          end else begin
            r_tap <= r_tap + 4'd1;
          end
        end
        S_ACC: begin
          r_state <= S_WR0;
          r_cwr   <= 1'b1;
          r_csel  <= 3'b001;
          r_caddr <= {w_row, w_col};
          r_cdata <= w_res;
        end
        S_WR0: begin
          r_pix <= r_pix + {{(2*L-1){1'b0}}, 1'b1};
`ifdef CONV_POOL_EN
          if (r_pix[1:0] == 2'd3) begin
            r_state <= S_WR1;
            r_cwr   <= 1'b1;
            r_csel  <= 3'b011;
            r_caddr <= {2'b00, r_pix[2*L-1:2]};
            r_cdata <= r_max;
          end else begin
            r_state <= S_TAP;
          end
`else
          if (&r_pix) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_TAP;
          end
`endif
        end
`ifdef CONV_POOL_EN
        S_WR1: begin
          if (r_pix == '0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_TAP;
          end
        end
`endif
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign cwr      = r_cwr;
  assign csel     = r_csel;
  assign iaddr    = r_iaddr;
  assign caddr_wr = r_caddr;
  assign cdata_wr = r_cdata;

endmodule

// File: tb/tb_conv3x3_relu_pool_engine.sv
// tb_conv3x3_relu_pool_engine: random and directed frames against an
// arithmetic reference of conv/ReLU/saturate/pool on an 8x8 image.
module tb_conv3x3_relu_pool_engine;

  localparam int L  = 3;
  localparam int W  = 8;
  localparam int N  = 64;
  localparam int DW = 20;
  localparam int KW = 20;
`ifdef CONV_POOL_EN
  localparam bit POOL = 1'b1;
`else
  localparam bit POOL = 1'b0;
`endif
  localparam int FRAME = N * 11 + (POOL ? N / 4 : 0);

  logic          clk;
  logic          reset;
  logic          ready;
  logic          busy;
  logic          k_we;
  logic [3:0]    k_idx;
  logic [KW-1:0] k_data;
  logic [2*L-1:0] iaddr;
  logic [DW-1:0] idata;
  logic          cwr;
  logic [2:0]    csel;
  logic [2*L-1:0] caddr_wr;
  logic [DW-1:0] cdata_wr;
  logic          done;

  logic [DW-1:0] img [0:N-1];
  longint        wm [0:8];
  longint        bm;
  logic [28:0]   exp_q [$];
  int            n_chk = 0;
  int            n_pass = 0;

  assign idata = img[iaddr];

  conv3x3_relu_pool_engine #(
    .IMG_LOG2(L), .DW(DW), .KW(KW), .FRAC(16)
  ) u_dut (
    .clk(clk), .reset(reset), .ready(ready), .busy(busy),
    .k_we(k_we), .k_idx(k_idx), .k_data(k_data),
    .iaddr(iaddr), .idata(idata),
    .cwr(cwr), .csel(csel), .caddr_wr(caddr_wr),
    .cdata_wr(cdata_wr), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic longint ref_px(int r, int c);
    longint a;
    a = bm * 65536;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++) begin
        int rr, cc;
        rr = r + dr - 1;
        cc = c + dc - 1;
        if (rr >= 0 && rr < W && cc >= 0 && cc < W)
          a += longint'(img[rr*W+cc]) * wm[dr*3+dc];
      end
    a = (a + 32768) >>> 16;
    if (a < 0) return 0;
    if (a > (longint'(1) << DW) - 1) return (longint'(1) << DW) - 1;
    return a;
  endfunction

  function automatic void build_exp();
    exp_q.delete();
    for (int wr = 0; wr < W/2; wr++)
      for (int wc = 0; wc < W/2; wc++) begin
        longint mx;
        mx = 0;
        for (int s = 0; s < 4; s++) begin
          int r, c;
          longint v;
          r = 2*wr + s/2;
          c = 2*wc + s%2;
          v = ref_px(r, c);
          if (v > mx) mx = v;
          exp_q.push_back({3'b001, 6'(r*W+c), 20'(v)});
        end
        if (POOL) exp_q.push_back({3'b011, 6'(wr*(W/2)+wc), 20'(mx)});
      end
  endfunction

  task automatic load_k();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      k_we   = 1'b1;
      k_idx  = 4'(i);
      k_data = KW'(i < 9 ? wm[i] : bm);
    end
    @(negedge clk);
    k_we = 1'b0;
  endtask

  task automatic set_k(input longint w, input longint b);
    for (int i = 0; i < 9; i++) wm[i] = w;
    bm = b;
  endtask

  task automatic fill(input logic [DW-1:0] v);
    for (int i = 0; i < N; i++) img[i] = v;
  endtask

  task automatic run_frame(input string tag, input bit hold, input bit poke);
    logic [28:0] e;
    int nb;
    bit saw;
    build_exp();
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    if (!hold) ready = 1'b0;
    nb = 0;
    saw = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (poke && k == 40) begin
        k_we = 1'b1; k_idx = 4'd4; k_data = '0;
      end
      if (poke && k == 41) k_we = 1'b0;
      if (busy) nb++;
      if (cwr) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 29'h1FFFFFFF;
        chk({tag, ":wr"}, {csel, caddr_wr, cdata_wr}, e);
      end
      if (done) begin
        saw = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, ":done"}, saw, 1);
    chk({tag, ":left"}, exp_q.size(), 0);
    chk({tag, ":cyc"}, nb, FRAME + 1);
    @(negedge clk);
    ready = 1'b0;
    chk({tag, ":idle"}, {busy, done}, 0);
    @(negedge clk);
    chk({tag, ":norestart"}, busy, 0);
  endtask

  initial begin
    int nw;
    bit act;
    reset = 1'b1; ready = 1'b0; k_we = 1'b0; k_idx = '0; k_data = '0;
    fill('0);
    set_k(0, 0);
    repeat (3) @(negedge clk);
    chk("rst:ctl", {busy, cwr, done, csel}, 0);
    chk("rst:addr", {iaddr, caddr_wr}, 0);
    chk("rst:data", cdata_wr, 0);
    reset = 1'b0;

    fill(20'h10000); set_k('h10000, 0); load_k();
    run_frame("s1", 1'b1, 1'b0);

    set_k(-'h10000, 'h8000); load_k();
    run_frame("s2", 1'b0, 1'b0);

    fill(20'hFFFFF); set_k('h10000, 0); load_k();
    run_frame("s3", 1'b0, 1'b0);

    for (int i = 0; i < N; i++) img[i] = DW'($urandom_range(0, 1));
    set_k(0, 0); wm[4] = 'h8000; load_k();
    run_frame("s4", 1'b0, 1'b0);

    fill('0); img[5*W+5] = 20'h20000;
    set_k(0, 0); wm[4] = 'h10000; load_k();
    run_frame("s5", 1'b0, 1'b0);

    fill(20'h10000); set_k('h10000, 0); load_k();
    @(negedge clk); ready = 1'b1;
    @(negedge clk); ready = 1'b0;
    nw = 0;
    for (int k = 0; k < 400; k++) begin
      if (cwr && csel == 3'b001) nw++;
      if (nw == 10) break;
      @(negedge clk);
    end
    chk("s6:reach", nw, 10);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("s6:busy", busy, 0);
    chk("s6:cwr", cwr, 0);
    act = 1'b0;
    repeat (30) begin
      @(negedge clk);
      act |= busy | cwr | done;
    end
    chk("s6:quiet", act, 0);
    set_k(0, 0);
    run_frame("s6z", 1'b0, 1'b0);
    set_k('h10000, 0); load_k();
    run_frame("s6b", 1'b0, 1'b1);

    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < N; i++) img[i] = DW'($urandom_range(0, 'h3FFFF));
      for (int i = 0; i < 9; i++)
        wm[i] = longint'($urandom_range(0, 'h40000)) - 'h20000;
      bm = longint'($urandom_range(0, 'h40000)) - 'h20000;
      load_k();
      run_frame($sformatf("rnd%0d", f), 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
